// File: rtl/ifu_pc_gen.sv
// Fetch-address generator: sequential PC issue, EX redirects and redirects deferred across a hold.
// Optional redirect counter is enabled by defining IFU_PC_REDIRECT_CNT_EN.
module ifu_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  input  logic        fetch_ready_i,
  output logic [31:0] pc_o,
  output logic        pc_valid_o,
  output logic        flush_o,
  output logic        misalign_o
`ifdef IFU_PC_REDIRECT_CNT_EN
  ,
  output logic [31:0] redirect_cnt_o
`endif
);

  localparam int unsigned STATE_W = 2;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [STATE_W-1:0] BOOT = 2'd0;
  localparam logic [STATE_W-1:0] RUN  = 2'd1;
  localparam logic [STATE_W-1:0] PEND = 2'd2;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic [ADDR_W-1:0]  pc_nxt;
  logic [ADDR_W-1:0]  pend_addr;
  logic [ADDR_W-1:0]  pend_nxt;
  logic [ADDR_W-1:0]  target;
  logic               accept;

  // State and address registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      pc_o      <= RESET_PC;
      pend_addr <= '0;
    end else begin
      state     <= state_nxt;
      pc_o      <= pc_nxt;
      pend_addr <= pend_nxt;
    end
  end

  // Next-state, next-PC and combinational handshake/flush outputs
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc_o;
    pend_nxt   = pend_addr;
    pc_valid_o = 1'b0;
    flush_o    = jump_flag_i;
    misalign_o = jump_flag_i & (|jump_addr_i[1:0]);
    target     = {jump_addr_i[ADDR_W-1:2], 2'b00};

    if (state == RUN) begin
      pc_valid_o = ~hold_i;
    end
    accept = pc_valid_o & fetch_ready_i;

    if (jump_flag_i) begin
      // A redirect overrides any outstanding request; under hold it is parked
      if (hold_i) begin
        pend_nxt  = target;
        state_nxt = PEND;
      end else begin
        pc_nxt    = target;
        state_nxt = RUN;
      end
    end else begin
      case (state)
        BOOT: state_nxt = RUN;
        PEND: begin
          if (!hold_i) begin
            pc_nxt    = pend_addr;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (accept) begin
            pc_nxt = pc_o + PC_STEP;
          end
        end
        default: state_nxt = BOOT;
      endcase
    end
  end

`ifdef IFU_PC_REDIRECT_CNT_EN
  // Counts every redirect pulse, held or not; wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_o <= '0;
    end else if (jump_flag_i) begin
      redirect_cnt_o <= redirect_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_pc_gen.sv
// Self-checking bench for ifu_pc_gen: directed scenarios plus randomized traffic against a behavioural model.
module tb_ifu_pc_gen;

  logic        clk;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_i;
  logic        fetch_ready_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        flush_o;
  logic        misalign_o;
`ifdef IFU_PC_REDIRECT_CNT_EN
  logic [31:0] redirect_cnt_o;
`endif

  int checks;
  int failures;

  // Model: current fetch address, boot flag, at-most-one parked redirect
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_known;
  logic [31:0] pend_q[$];
  logic [31:0] m_cnt;

  // Snapshot of the outputs seen in the most recent cycle
  logic [31:0] s_pc;
  logic        s_valid;
  logic        s_flush;
  logic        s_mis;

  ifu_pc_gen dut (
    .clk           (clk),
    .rst           (rst),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .hold_i        (hold_i),
    .fetch_ready_i (fetch_ready_i),
    .pc_o          (pc_o),
    .pc_valid_o    (pc_valid_o),
    .flush_o       (flush_o),
    .misalign_o    (misalign_o)
`ifdef IFU_PC_REDIRECT_CNT_EN
    ,
    .redirect_cnt_o(redirect_cnt_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare at negedge, advance the model at posedge
  task automatic cyc(input logic r, input logic j, input logic [31:0] a, input logic h, input logic f);
    logic [31:0] tgt;
    rst = r; jump_flag_i = j; jump_addr_i = a; hold_i = h; fetch_ready_i = f;
    @(negedge clk);
    if (m_known) begin
      chk("pc", pc_o, m_pc);
      chk("pc_valid", 32'(pc_valid_o), 32'(!m_boot && pend_q.size() == 0 && !h));
      chk("flush", 32'(flush_o), 32'(j));
      chk("misalign", 32'(misalign_o), 32'(j && a[1:0] != 2'b00));
`ifdef IFU_PC_REDIRECT_CNT_EN
      chk("redirect_cnt", redirect_cnt_o, m_cnt);
`endif
    end
    s_pc = pc_o; s_valid = pc_valid_o; s_flush = flush_o; s_mis = misalign_o;
    @(posedge clk);
    tgt = a & ~32'd3;
    if (r) begin
      m_pc = 32'h0; m_boot = 1'b1; m_known = 1'b1; m_cnt = 32'h0;
      pend_q.delete();
    end else if (m_known) begin
      if (j) begin
        m_cnt = m_cnt + 32'd1;
        m_boot = 1'b0;
        pend_q.delete();
        if (h) pend_q.push_back(tgt);
        else   m_pc = tgt;
      end else if (pend_q.size() != 0) begin
        if (!h) m_pc = pend_q.pop_front();
      end else if (m_boot) begin
        m_boot = 1'b0;
      end else if (!h && f) begin
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    m_known = 1'b0; m_boot = 1'b1; m_pc = '0; m_cnt = '0;
    rst = 1'b1; jump_flag_i = 1'b0; jump_addr_i = '0; hold_i = 1'b0; fetch_ready_i = 1'b0;

    // 1. reset release, sequential fetch
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t1_boot_valid", 32'(s_valid), 32'd0);
    chk("t1_boot_pc", s_pc, 32'h0);
    cyc(0, 0, 0, 0, 1);
    chk("t1_pc0", s_pc, 32'h0);
    chk("t1_valid", 32'(s_valid), 32'd1);
    cyc(0, 0, 0, 0, 1);
    chk("t1_pc4", s_pc, 32'h4);
    cyc(0, 0, 0, 0, 1);
    chk("t1_pc8", s_pc, 32'h8);

    // 2. unheld redirect
    cyc(0, 1, 32'h0000_0100, 0, 1);
    chk("t2_flush", 32'(s_flush), 32'd1);
    cyc(0, 0, 0, 0, 1);
    chk("t2_pc100", s_pc, 32'h100);
    chk("t2_valid", 32'(s_valid), 32'd1);
    cyc(0, 0, 0, 0, 1);
    chk("t2_pc104", s_pc, 32'h104);

    // 3. redirect under hold, released at N+4
    cyc(0, 1, 32'h0000_0200, 1, 1);
    chk("t3_flush", 32'(s_flush), 32'd1);
    chk("t3_validN", 32'(s_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 1);
      chk("t3_valid_hold", 32'(s_valid), 32'd0);
    end
    cyc(0, 0, 0, 0, 1);
    chk("t3_valid_release", 32'(s_valid), 32'd0);
    cyc(0, 0, 0, 0, 1);
    chk("t3_pc200", s_pc, 32'h200);
    chk("t3_valid", 32'(s_valid), 32'd1);

    // 4. misaligned redirect with IFU stalled
    cyc(0, 1, 32'h0000_0302, 0, 0);
    chk("t4_misalign", 32'(s_mis), 32'd1);
    cyc(0, 0, 0, 0, 0);
    chk("t4_pc300", s_pc, 32'h300);
    cyc(0, 0, 0, 0, 0);
    chk("t4_pc300_held", s_pc, 32'h300);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t4_pc304", s_pc, 32'h304);

    // 5. wrap and reset while pending
    cyc(0, 1, 32'hFFFF_FFFC, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t5_pc_top", s_pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 1);
    chk("t5_pc_wrap", s_pc, 32'h0);
    cyc(0, 1, 32'h0000_0400, 1, 1);
    cyc(1, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t5_rst_pc", s_pc, 32'h0);
    chk("t5_rst_valid", 32'(s_valid), 32'd0);

`ifdef IFU_PC_REDIRECT_CNT_EN
    // 6. three redirects, one held
    cyc(0, 1, 32'h10, 0, 1);
    cyc(0, 1, 32'h20, 1, 1);
    cyc(0, 1, 32'h30, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t6_cnt3", redirect_cnt_o, 32'd3);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic        r, j, h, f;
      logic [31:0] a;
      r = ($urandom_range(0, 199) == 0);
      j = ($urandom_range(0, 99) < 15);
      h = ($urandom_range(0, 99) < 25);
      f = ($urandom_range(0, 99) < 70);
      a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      cyc(r, j, a, h, f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
